sun_pll_rosc_ctrl: RTL and testbench
====================================

Name: sun_pll_rosc_ctrl

Overview:
Digital startup and lock controller for the PLL ring oscillator.
- Drives the oscillator power-up enable.
- Waits a settle time, then repeatedly measures oscillator frequency by counting edges of the divided, pre-synchronised oscillator clock over a fixed reference window.
- Declares LOCK after a run of in-tolerance measurements, or FAIL after too many misses.
- Sits in the digital core, clocked by the reference clock. Its PWRUP_1V8 output goes through the 1V8 level shifter to the oscillator.

Parameters:
CNT_W, 10, width of edge counter, TARGET, TOL and FREQ_CNT
SETTLE_CYCLES, 16, CK cycles spent in SETTLE after power-up (>=1)
WINDOW_CYCLES, 64, CK cycles per measurement window (>=2)
LOCK_COUNT, 4, consecutive good windows required for LOCK (>=1)
MAX_MISS, 8, bad windows tolerated before FAIL while not locked (>=1)

Ports:
CK  input  1  reference clock; all logic on rising edge
RST  input  1  synchronous reset, active high
EN  input  1  controller enable; low forces OFF
ROSC_DIV  input  1  divided oscillator clock, already synchronised to CK
TARGET  input  CNT_W  expected edge count per window
TOL  input  CNT_W  allowed absolute deviation from TARGET
PWRUP_1V8  output  1  oscillator power-up request (to level shifter)
LOCK  output  1  frequency locked
FAIL  output  1  lock not achieved, sticky until EN low
FREQ_VALID  output  1  one-cycle pulse, FREQ_CNT updated
FREQ_CNT  output  CNT_W  last completed window edge count
STATE  output  3  current FSM state encoding

Behaviour:
Reset (RST=1 at a CK edge):
- State OFF.
- All outputs 0: PWRUP_1V8, LOCK, FAIL, FREQ_VALID, FREQ_CNT=0, STATE=0.
- All internal counters 0, edge-detect register 0.
- Reset applies in any state, including mid-window.

State encoding: OFF=0, SETTLE=1, MEASURE=2, LOCKED=3, FAIL=4.

OFF:
- PWRUP_1V8=0.
- EN=1 -> SETTLE.

SETTLE:
- PWRUP_1V8=1.
- Stays exactly SETTLE_CYCLES cycles, then -> MEASURE.
- Edge count, good streak and miss counter all cleared.

MEASURE and LOCKED (PWRUP_1V8=1 in both):
- Edge detect: edge = ROSC_DIV & ~prev, where prev is the registered ROSC_DIV.
- Window counter runs 0..WINDOW_CYCLES-1. Edges on every window cycle are counted, including the first and the last.
- Edge counter saturates at 2^CNT_W-1 and never wraps.
- On the cycle after the last window cycle:
  - FREQ_CNT <= count, FREQ_VALID=1 for that one cycle.
  - The count restarts, with that cycle's edge counted as the first of the next window.
  - Windows are back-to-back with no gap.
- Good window: |count - TARGET| <= TOL, computed at CNT_W+1 bits with no overflow. TOL=0 requires an exact match.

MEASURE on a result:
- Good: streak+1. If streak reaches LOCK_COUNT -> LOCKED, and LOCK rises in the same cycle as that FREQ_VALID.
- Bad: streak=0, miss+1. If miss reaches MAX_MISS -> FAIL, and FAIL rises with that FREQ_VALID.

LOCKED:
- Good result: stay.
- Bad result: LOCK=0 with that FREQ_VALID, -> MEASURE, streak=0, miss=0.

FAIL:
- PWRUP_1V8=0, FAIL=1, LOCK=0.
- No measurement; FREQ_CNT holds its last value.
- Exits only via EN=0.

EN=0 in any non-OFF state:
- Next state OFF.
- PWRUP_1V8, LOCK and FAIL are 0 from the next cycle.
- The window in progress is discarded with no FREQ_VALID.
- FREQ_CNT holds.

EN re-asserted:
- Full restart via SETTLE.

Simultaneous events:
- RST beats EN.
- EN=0 beats a window completion in the same cycle: no FREQ_VALID, no state update.

Output timing: all outputs registered; no combinational paths from inputs.

Test Plan:
1. Reset/idle: RST=1 for 2 cycles with EN=1, then RST=0 -> all outputs 0 during reset; PWRUP_1V8=1 one cycle after reset release.
2. Nominal lock (defaults), TARGET=16, TOL=1, ROSC_DIV period 4 CK -> PWRUP_1V8=1 at cycle 1 after EN sampled; FREQ_VALID every 64 cycles with FREQ_CNT=16; LOCK=1 on the 4th FREQ_VALID, cycle 273.
3. Tolerance edge: ROSC_DIV gives 17 edges, TOL=1 -> good; 18 edges -> bad, streak cleared, LOCK still 0 after 4 further windows when one of every 4 windows is 18.
4. Fail: TARGET=40, TOL=2, 16 edges per window -> FAIL=1 and PWRUP_1V8=0 after the 8th FREQ_VALID; stays until EN=0.
5. Loss of lock: after LOCK, change ROSC_DIV to period 8 (8 edges) -> LOCK falls with the next FREQ_VALID; restoring period 4 re-locks after 4 good windows; FAIL stays 0.
6. Saturation and abort: ROSC_DIV period 2 with CNT_W=4 -> FREQ_CNT=15, not wrapped; EN=0 mid-window -> no FREQ_VALID, OFF next cycle, FREQ_CNT held.

Source files
------------

// File: rtl/sun_pll_rosc_ctrl.sv
// Startup and lock controller for the PLL ring oscillator: power-up, settle,
// repeated frequency measurement over a reference window, then LOCK or FAIL.
module sun_pll_rosc_ctrl #(
    parameter int CNT_W         = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 64,
    parameter int LOCK_COUNT    = 4,
    parameter int MAX_MISS      = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic             ROSC_DIV,
    input  logic [CNT_W-1:0] TARGET,
    input  logic [CNT_W-1:0] TOL,
    output logic             PWRUP_1V8,
    output logic             LOCK,
    output logic             FAIL,
    output logic             FREQ_VALID,
    output logic [CNT_W-1:0] FREQ_CNT,
    output logic [2:0]       STATE
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int KW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MAX_MISS + 1);

    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [KW-1:0] LOCK_N   = KW'(LOCK_COUNT);
    localparam logic [MW-1:0] MISS_N   = MW'(MAX_MISS);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_LOCKED  = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    state_t           state, next_state;
    logic [SW-1:0]    set_cnt;
    logic [WW-1:0]    win_cnt;
    logic [CNT_W-1:0] edge_cnt, cnt_inc;
    logic [KW-1:0]    streak, streak_n, streak_inc;
    logic [MW-1:0]    miss, miss_n, miss_inc;
    logic             prev, rise, measuring, win_done, good;
    logic [CNT_W:0]   cnt_ext, tgt_ext, diff;

    assign rise       = ROSC_DIV & ~prev;
    assign cnt_inc    = (rise && (edge_cnt != {CNT_W{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;
    assign measuring  = (state == S_MEASURE) || (state == S_LOCKED);
    // Dropping EN wins over a completing window: the result is discarded.
    assign win_done   = measuring && EN && (win_cnt == WIN_LAST);
    assign cnt_ext    = {1'b0, cnt_inc};
    assign tgt_ext    = {1'b0, TARGET};
    assign diff       = (cnt_ext >= tgt_ext) ? cnt_ext - tgt_ext : tgt_ext - cnt_ext;
    assign good       = diff <= {1'b0, TOL};
    assign streak_inc = streak + 1'b1;
    assign miss_inc   = miss + 1'b1;

    always_comb begin
        next_state = state;
        streak_n   = streak;
        miss_n     = miss;
        case (state)
            S_OFF: begin
                if (EN) next_state = S_SETTLE;
            end
            S_SETTLE: begin
                streak_n = '0;
                miss_n   = '0;
                if (!EN)                    next_state = S_OFF;
                else if (set_cnt == SET_LAST) next_state = S_MEASURE;
            end
            S_MEASURE: begin
                if (!EN) begin
                    next_state = S_OFF;
                end else if (win_done) begin
                    if (good) begin
                        streak_n = streak_inc;
                        if (streak_inc >= LOCK_N) next_state = S_LOCKED;
                    end else begin
                        streak_n = '0;
                        miss_n   = miss_inc;
                        if (miss_inc >= MISS_N) next_state = S_FAIL;
                    end
                end
            end
            S_LOCKED: begin
                if (!EN) begin
                    next_state = S_OFF;
                end else if (win_done && !good) begin
                    next_state = S_MEASURE;
                    streak_n   = '0;
                    miss_n     = '0;
                end
            end
            S_FAIL: begin
                if (!EN) next_state = S_OFF;
            end
            default: next_state = S_OFF;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= S_OFF;
            set_cnt    <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            streak     <= '0;
            miss       <= '0;
            prev       <= 1'b0;
            FREQ_CNT   <= '0;
            FREQ_VALID <= 1'b0;
            PWRUP_1V8  <= 1'b0;
            LOCK       <= 1'b0;
            FAIL       <= 1'b0;
        end else begin
            state      <= next_state;
            prev       <= ROSC_DIV;
            streak     <= streak_n;
            miss       <= miss_n;
            set_cnt    <= (state == S_SETTLE && next_state == S_SETTLE) ? set_cnt + 1'b1 : '0;
            FREQ_VALID <= win_done;
            if (win_done) FREQ_CNT <= cnt_inc;
            // Windows run back-to-back; the cycle after completion is the
            // first cycle of the next window.
            if (measuring && EN) begin
                if (win_done) begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                end else begin
                    win_cnt  <= win_cnt + 1'b1;
                    edge_cnt <= cnt_inc;
                end
            end else begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end
            PWRUP_1V8 <= (next_state == S_SETTLE) || (next_state == S_MEASURE) ||
                         (next_state == S_LOCKED);
            LOCK      <= (next_state == S_LOCKED);
            FAIL      <= (next_state == S_FAIL);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_sun_pll_rosc_ctrl.sv
// Scoreboard bench for sun_pll_rosc_ctrl: directed windows of known edge
// counts, expected results queued ahead and checked on every FREQ_VALID.
module tb_sun_pll_rosc_ctrl;

    logic       CK = 1'b0;
    logic       RST, EN, en2, ROSC_DIV;
    logic [9:0] TARGET, TOL;
    logic [3:0] target2, tol2;
    logic       PWRUP_1V8, LOCK, FAIL, FREQ_VALID;
    logic [9:0] FREQ_CNT;
    logic [2:0] STATE;
    logic       pwrup2, lock2, fail2, fv2;
    logic [3:0] fcnt2;
    logic [2:0] st2;

    always #5 CK = ~CK;

    sun_pll_rosc_ctrl dut (
        .CK(CK), .RST(RST), .EN(EN), .ROSC_DIV(ROSC_DIV), .TARGET(TARGET), .TOL(TOL),
        .PWRUP_1V8(PWRUP_1V8), .LOCK(LOCK), .FAIL(FAIL), .FREQ_VALID(FREQ_VALID),
        .FREQ_CNT(FREQ_CNT), .STATE(STATE)
    );

    sun_pll_rosc_ctrl #(.CNT_W(4)) dut2 (
        .CK(CK), .RST(RST), .EN(en2), .ROSC_DIV(ROSC_DIV), .TARGET(target2), .TOL(tol2),
        .PWRUP_1V8(pwrup2), .LOCK(lock2), .FAIL(fail2), .FREQ_VALID(fv2),
        .FREQ_CNT(fcnt2), .STATE(st2)
    );

    typedef struct packed {
        logic [9:0] cnt;
        logic       lock;
        logic       fail;
        logic [2:0] st;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   nchk = 0;
    int   nerr = 0;

    // Directed windows: edges per window and resulting state.
    int t3n [17] = '{17,16,16,18,16,16,16,18,16,16,16,16, 8,16,16,16,16};
    int t3s [17] = '{ 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 2, 2, 2, 2, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CK) begin
        if (FREQ_VALID) begin
            if (q1.size() == 0) chk("dut1 unexpected FREQ_VALID", 32'd1, 32'd0);
            else chk("dut1 result {cnt,lock,fail,st}",
                     {17'd0, FREQ_CNT, LOCK, FAIL, STATE}, {17'd0, q1.pop_front()});
        end
        if (fv2) begin
            if (q2.size() == 0) chk("dut2 unexpected FREQ_VALID", 32'd1, 32'd0);
            else chk("dut2 result {cnt,lock,fail,st}",
                     {17'd0, 6'd0, fcnt2, lock2, fail2, st2}, {17'd0, q2.pop_front()});
        end
    end

    // n single-cycle pulses at offsets 1,4,7,... inside a 64-cycle window.
    function automatic logic pulse(input int off, input int n);
        return (n > 0) && (off >= 1) && (off <= 3 * (n - 1) + 1) && ((off - 1) % 3 == 0);
    endfunction

    // Called at the start of a window's first cycle; abort>=0 drops EN on that offset.
    task automatic run_win(input int n, input int c1, input int l1, input int f1, input int s1,
                           input int use2, input int c2, input int s2, input int abort);
        if (abort < 0) begin
            q1.push_back({10'(c1), 1'(l1), 1'(f1), 3'(s1)});
            if (use2 != 0) q2.push_back({10'(c2), 1'b0, 1'b0, 3'(s2)});
        end
        for (int off = 0; off < 64; off++) begin
            if (off == abort) begin
                EN  = 1'b0;
                en2 = 1'b0;
            end
            ROSC_DIV = pulse(off, n);
            @(posedge CK); #1;
            if (off == abort) return;
        end
    endtask

    task automatic restart(input logic with2);
        EN = 1'b0; en2 = 1'b0; ROSC_DIV = 1'b0;
        @(posedge CK); #1;
        EN = 1'b1; en2 = with2;
        @(posedge CK); #1;
        repeat (16) @(posedge CK);
        #1;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; en2 = 1'b0; ROSC_DIV = 1'b0;
        TARGET = 10'd16; TOL = 10'd1; target2 = 4'd15; tol2 = 4'd0;

        // Reset with EN high: everything held at zero.
        for (int i = 0; i < 2; i++) begin
            @(negedge CK);
            chk("reset outputs", {PWRUP_1V8, LOCK, FAIL, FREQ_VALID, FREQ_CNT, STATE}, 32'd0);
        end
        @(posedge CK); #1;
        RST = 1'b0;
        chk("pwrup before EN sampled", {31'd0, PWRUP_1V8}, 32'd0);
        @(posedge CK); #1;
        chk("pwrup cycle 1", {31'd0, PWRUP_1V8}, 32'd1);
        chk("settle state", {29'd0, STATE}, 32'd1);
        repeat (15) @(posedge CK);
        #1;
        chk("still settle cycle 16", {29'd0, STATE}, 32'd1);
        @(posedge CK); #1;
        chk("measure cycle 17", {29'd0, STATE}, 32'd2);

        // Nominal lock: four windows of 16 edges, LOCK on the 4th result (cycle 273).
        run_win(16, 16, 0, 0, 2, 0, 0, 0, -1);
        chk("first FREQ_VALID at cycle 81", {31'd0, FREQ_VALID}, 32'd1);
        run_win(16, 16, 0, 0, 2, 0, 0, 0, -1);
        run_win(16, 16, 0, 0, 2, 0, 0, 0, -1);
        chk("no lock before cycle 273", {31'd0, LOCK}, 32'd0);
        run_win(16, 16, 1, 0, 3, 0, 0, 0, -1);
        chk("lock at cycle 273", {30'd0, LOCK, FREQ_VALID}, 32'd3);

        // Tolerance edges, streak clears on a bad window, then loss and re-lock.
        restart(1'b0);
        for (int i = 0; i < 17; i++)
            run_win(t3n[i], t3n[i], (t3s[i] == 3) ? 1 : 0, 0, t3s[i], 0, 0, 0, -1);

        // Unreachable target: FAIL on the 8th result, sticky until EN drops.
        TARGET = 10'd40; TOL = 10'd2;
        restart(1'b0);
        for (int i = 0; i < 8; i++)
            run_win(16, 16, 0, (i == 7) ? 1 : 0, (i == 7) ? 4 : 2, 0, 0, 0, -1);
        chk("fail pwrup/fail", {30'd0, PWRUP_1V8, FAIL}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            ROSC_DIV = i[1];
            @(posedge CK); #1;
        end
        chk("fail held", {18'd0, FAIL, STATE, FREQ_CNT}, {18'd0, 1'b1, 3'd4, 10'd16});
        EN = 1'b0;
        @(posedge CK); #1;
        chk("fail cleared by EN", {16'd0, PWRUP_1V8, LOCK, FAIL, STATE, FREQ_CNT},
            {16'd0, 3'b000, 3'd0, 10'd16});

        // Saturation on the 4-bit instance, then EN drop on a window's last cycle.
        TARGET = 10'd16; TOL = 10'd1;
        restart(1'b1);
        run_win(20, 20, 0, 0, 2, 1, 15, 2, -1);
        run_win(16, 16, 0, 0, 2, 1, 15, 2, -1);
        run_win(16, 0, 0, 0, 0, 0, 0, 0, 63);
        chk("abort at window end", {13'd0, FREQ_VALID, PWRUP_1V8, STATE, FREQ_CNT, fcnt2, st2},
            {13'd0, 1'b0, 1'b0, 3'd0, 10'd16, 4'd15, 3'd0});

        // EN drop mid-window: partial window discarded, counts held.
        restart(1'b1);
        run_win(5, 5, 0, 0, 2, 1, 5, 2, -1);
        run_win(10, 0, 0, 0, 0, 0, 0, 0, 30);
        chk("abort mid-window", {14'd0, PWRUP_1V8, STATE, FREQ_CNT, fcnt2},
            {14'd0, 1'b0, 3'd0, 10'd5, 4'd5});
        repeat (80) @(posedge CK);
        #1;
        chk("dut1 results outstanding", q1.size(), 32'd0);
        chk("dut2 results outstanding", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
